// File: rtl/counter_a_pkg.sv
// Shared constants for the Basys 3 counter/light block.
// No logic; width and default prescale used by counter_a and tick_gen.
// No flow control.
package counter_a_pkg;

    localparam int CNT_W            = 6;
    // One increment per second from the 100 MHz board clock.
    localparam int TICK_DIV_DEFAULT = 100_000_000;

    // Prescaler register width: ceil(log2(div)), never below one bit.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/counter_a_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clk edges.
// Latency: tick is combinational from div_cnt/en, asserted on the edge that wraps div_cnt.
// No backpressure; en=0 freezes div_cnt so partial progress survives a pause.
module tick_gen
    import counter_a_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              DIV_W   = div_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && (div_cnt == DIV_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_a.sv
// Free-running modulo-64 up-counter advanced by the tick_gen prescaler.
// Latency: first increment TICK_DIV enabled edges after reset, then every TICK_DIV.
// No backpressure; cnt_en=0 pauses both counter and prescaler.
module counter_a
    import counter_a_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CNT_W    = counter_a_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt
);

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .tick (tick)
    );

    // Natural overflow of the CNT_W-bit register gives the 63 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_a.sv
// Directed bench for counter_a with TICK_DIV=1 and TICK_DIV=4 instances.
// Expected counts are hand-computed constants.
module tb_counter_a;

    logic       clk = 1'b0;
    logic       rst1, en1, rst4, en4;
    logic [5:0] cnt1, cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_a #(.TICK_DIV(1), .CNT_W(6)) u_dut1 (
        .clk    (clk),
        .rst    (rst1),
        .cnt_en (en1),
        .cnt    (cnt1)
    );

    counter_a #(.TICK_DIV(4), .CNT_W(6)) u_dut4 (
        .clk    (clk),
        .rst    (rst4),
        .cnt_en (en4),
        .cnt    (cnt4)
    );

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst1 = 1'b1; en1 = 1'b1;
        rst4 = 1'b1; en4 = 1'b1;

        // TICK_DIV=1: reset held with enable high keeps cnt at 0
        step(1); check("d1_rst_hold0", cnt1, 6'd0);
        step(1); check("d1_rst_hold1", cnt1, 6'd0);
        rst1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1); check("d1_release", cnt1, 6'(k));
        end

        // Enable gating at 20
        step(17); check("d1_reach20", cnt1, 6'd20);
        en1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1); check("d1_pause", cnt1, 6'd20);
        end
        en1 = 1'b1;
        step(1); check("d1_resume", cnt1, 6'd21);

        // Wrap 63 -> 0 -> 1
        rst1 = 1'b1; step(1); check("d1_wrap_rst", cnt1, 6'd0);
        rst1 = 1'b0;
        step(63); check("d1_at63", cnt1, 6'd63);
        step(1);  check("d1_wrap0", cnt1, 6'd0);
        step(1);  check("d1_wrap1", cnt1, 6'd1);

        // Mid-count reset coinciding with a tick: reset wins
        rst1 = 1'b1; step(1); rst1 = 1'b0;
        step(9); check("d1_mid9", cnt1, 6'd9);
        rst1 = 1'b1; step(1); check("d1_mid_rst", cnt1, 6'd0);
        rst1 = 1'b0; step(1); check("d1_mid_resume", cnt1, 6'd1);

        // TICK_DIV=4: increments on edges 4 and 8 only
        step(1); check("d4_rst", cnt4, 6'd0);
        rst4 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1); check("d4_prescale", cnt4, 6'(k / 4));
        end

        // Pause after 2 enabled edges keeps prescaler phase
        rst4 = 1'b1; step(1); rst4 = 1'b0;
        step(2); check("d4_pre_pause", cnt4, 6'd0);
        en4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1); check("d4_paused", cnt4, 6'd0);
        end
        en4 = 1'b1;
        step(1); check("d4_phase3", cnt4, 6'd0);
        step(1); check("d4_phase_tick", cnt4, 6'd1);

        // Mid-count reset with prescaler partway: phase must restart from 0
        rst4 = 1'b1; step(1); rst4 = 1'b0;
        step(36); check("d4_mid9", cnt4, 6'd9);
        step(2);  check("d4_mid_partial", cnt4, 6'd9);
        rst4 = 1'b1; step(1); check("d4_mid_rst", cnt4, 6'd0);
        rst4 = 1'b0;
        step(3); check("d4_restart3", cnt4, 6'd0);
        step(1); check("d4_restart4", cnt4, 6'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
